// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_pkg
//  Description : Shared definitions for the hazard scoreboard: per-register
//                entry record, producer latency constants and defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Storage width of the countdown and aging fields in an entry.
    localparam int SB_LAT_W       = 4;
    localparam int SB_AGE_W       = 3;
    localparam int SB_SPEC_CYCLES = 2;

    // Producer latencies (cycles until result is forwardable).
    localparam logic [SB_LAT_W-1:0] LAT_ALU     = 4'd0;
    localparam logic [SB_LAT_W-1:0] LAT_LOAD    = 4'd2;
    localparam logic [SB_LAT_W-1:0] LAT_MUL     = 4'd3;
    localparam logic [SB_LAT_W-1:0] LAT_DIV_MAX = 4'd15;

    typedef struct packed {
        logic                busy;
        logic [SB_LAT_W-1:0] cnt;
        logic                spec;
        logic [SB_AGE_W-1:0] age;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_entry.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_entry
//  Description : State of one tracked architectural register: pending-write
//                flag, latency countdown and speculation window.
//  Ports       : clk_i/reset_i  clock, synchronous active-low reset
//                set_i, lat_i   new in-flight write with its latency
//                wb_i           writeback to this register
//                flush_i        control-hazard squash
//                busy_o         write pending
//                pend_o         write pending and result not yet forwardable
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W       = SB_LAT_W,
    parameter int SPEC_CYCLES = SB_SPEC_CYCLES
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             set_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             wb_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             pend_o
);

    sb_entry_t entry_q;
    sb_entry_t entry_d;

    // Assignments are ordered lowest to highest priority so the last one
    // to fire wins: countdown/aging < issue < writeback < flush.
    always_comb begin
        entry_d = entry_q;
        if (entry_q.busy && (entry_q.cnt != '0)) begin
            entry_d.cnt = entry_q.cnt - 1'b1;
        end
        if (entry_q.age != '0) begin
            entry_d.age = entry_q.age - 1'b1;
        end
        // Speculation ends on the same edge the age reaches zero.
        entry_d.spec = entry_q.spec && (entry_d.age != '0);
        if (set_i) begin
            entry_d.busy = 1'b1;
            entry_d.cnt  = SB_LAT_W'(lat_i);
            entry_d.spec = 1'b1;
            entry_d.age  = SB_AGE_W'(SPEC_CYCLES);
        end
        if (wb_i) begin
            entry_d = '0;
        end
        if (flush_i && entry_q.spec) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign busy_o = entry_q.busy;
    assign pend_o = entry_q.busy && (entry_q.cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Issue-stage scoreboard for variable-latency producers.
//                Decides stall / bypass / proceed for the issuing
//                instruction and squashes speculative entries on flush.
//  Ports       : clk_i, reset_i (sync, active-low)
//                issue_*        instruction presented for issue
//                issue_ready_o  instruction may issue this cycle
//                wb_valid_i/wb_rd_i  register file writeback
//                flush_i        control hazard squash
//                src_fwd_o      per-source bypass select
//                busy_o         per-register pending-write flags
//  Options     : HAZARD_SCOREBOARD_PERF_EN adds stall_cycles_o (32b, wraps)
//                and waw_stalls_o (16b, saturates) performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int LAT_W       = SB_LAT_W,
    parameter int SPEC_CYCLES = SB_SPEC_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_rs_i,
    input  logic [NUM_SRC-1:0]            issue_rs_used_i,
    input  logic                          issue_we_i,
    input  logic [REG_ADDR_W-1:0]         issue_rd_i,
    input  logic [LAT_W-1:0]              issue_lat_i,
    input  logic                          wb_valid_i,
    input  logic [REG_ADDR_W-1:0]         wb_rd_i,
    input  logic                          flush_i,
    output logic [NUM_SRC-1:0]            src_fwd_o,
    output logic [NUM_REGS-1:0]           busy_o
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]                   stall_cycles_o,
    output logic [15:0]                   waw_stalls_o
`endif
);

    logic [NUM_REGS-1:0]   w_busy;
    logic [NUM_REGS-1:0]   w_pend;
    logic                  w_fire;
    logic                  w_src_haz;
    logic                  w_waw;
    logic [REG_ADDR_W-1:0] w_rs;
    logic                  w_rs_hit;

    assign w_fire = issue_valid_i && issue_ready_o;

    // Register 0 is hardwired and never tracked.
    assign w_busy[0] = 1'b0;
    assign w_pend[0] = 1'b0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            logic w_set;
            logic w_wb;
            assign w_set = w_fire && issue_we_i && (issue_rd_i == REG_ADDR_W'(r));
            assign w_wb  = wb_valid_i && (wb_rd_i == REG_ADDR_W'(r));

            hazard_scoreboard_entry #(
                .LAT_W       (LAT_W),
                .SPEC_CYCLES (SPEC_CYCLES)
            ) u_entry (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .set_i   (w_set),
                .lat_i   (issue_lat_i),
                .wb_i    (w_wb),
                .flush_i (flush_i),
                .busy_o  (w_busy[r]),
                .pend_o  (w_pend[r])
            );
        end
    endgenerate

    // A busy source stalls while its producer is still counting down and
    // must take the bypass once the count has drained.
    always_comb begin
        w_src_haz = 1'b0;
        src_fwd_o = '0;
        w_rs      = '0;
        w_rs_hit  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_rs         = issue_rs_i[s*REG_ADDR_W +: REG_ADDR_W];
            w_rs_hit     = issue_rs_used_i[s] && (w_rs != '0);
            src_fwd_o[s] = w_rs_hit && w_busy[w_rs] && !w_pend[w_rs];
            w_src_haz    = w_src_haz || (w_rs_hit && w_pend[w_rs]);
        end
    end

    assign w_waw         = issue_we_i && (issue_rd_i != '0) && w_busy[issue_rd_i];
    assign issue_ready_o = !flush_i && !w_src_haz && !w_waw;
    assign busy_o        = w_busy;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] waw_stalls_q;
    logic        w_stall;

    assign w_stall = issue_valid_i && !issue_ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stall_cycles_q <= '0;
            waw_stalls_q   <= '0;
        end else begin
            if (w_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (w_stall && w_waw && (waw_stalls_q != 16'hFFFF)) begin
                waw_stalls_q <= waw_stalls_q + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign waw_stalls_o   = waw_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. A timestamp-based
//                model (issue cycle + latency per register) predicts the
//                outputs every cycle; directed cases pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int LW   = 4;
    localparam int SPEC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic             issue_valid;
    logic             ready;
    logic [NS*AW-1:0] rs;
    logic [NS-1:0]    used;
    logic             we;
    logic [AW-1:0]    rd;
    logic [LW-1:0]    lat;
    logic             wbv;
    logic [AW-1:0]    wbrd;
    logic             flush;
    logic [NS-1:0]    fwd;
    logic [NR-1:0]    busy;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]      stall_cyc;
    logic [15:0]      waw_st;
`endif

    hazard_scoreboard #(
        .NUM_REGS    (NR),
        .REG_ADDR_W  (AW),
        .NUM_SRC     (NS),
        .LAT_W       (LW),
        .SPEC_CYCLES (SPEC)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_n),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (ready),
        .issue_rs_i      (rs),
        .issue_rs_used_i (used),
        .issue_we_i      (we),
        .issue_rd_i      (rd),
        .issue_lat_i     (lat),
        .wb_valid_i      (wbv),
        .wb_rd_i         (wbrd),
        .flush_i         (flush),
        .src_fwd_o       (fwd),
        .busy_o          (busy)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        ,
        .stall_cycles_o  (stall_cyc),
        .waw_stalls_o    (waw_st)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A register is pending from the cycle after its producer issues until
    // writeback; it stalls readers until cycle issue+1+lat.
    bit          m_pend [NR];
    int          m_issue[NR];
    int          m_lat  [NR];
    int          cyc     = 0;
    bit          started = 1'b0;
    logic [31:0] m_stall;
    int          m_waw;

    always @(negedge clk) begin
        bit            e_src;
        bit            e_waw;
        bit            e_ready;
        logic [NS-1:0] e_fwd;
        logic [NR-1:0] e_busy;
        int            r;
        e_src = 1'b0;
        e_fwd = '0;
        for (int s = 0; s < NS; s++) begin
            r = int'(rs[s*AW +: AW]);
            if (used[s] && r != 0 && m_pend[r]) begin
                if (cyc < m_issue[r] + 1 + m_lat[r]) e_src = 1'b1;
                else e_fwd[s] = 1'b1;
            end
        end
        e_waw   = we && rd != 0 && m_pend[int'(rd)];
        e_ready = !flush && !e_src && !e_waw;
        for (int k = 0; k < NR; k++) e_busy[k] = m_pend[k];

        if (started) begin
            chk("ready", 64'(ready), 64'(e_ready));
            chk("fwd",   64'(fwd),   64'(e_fwd));
            chk("busy",  64'(busy),  64'(e_busy));
`ifdef HAZARD_SCOREBOARD_PERF_EN
            chk("stall_cycles", 64'(stall_cyc), 64'(m_stall));
            chk("waw_stalls",   64'(waw_st),    64'(m_waw));
`endif
        end

        if (!reset_n) begin
            for (int k = 0; k < NR; k++) m_pend[k] = 1'b0;
            m_stall = '0;
            m_waw   = 0;
            started = 1'b1;
        end else begin
            if (issue_valid && !e_ready && !flush) begin
                m_stall = m_stall + 32'd1;
                if (e_waw && m_waw < 65535) m_waw++;
            end
            for (int k = 1; k < NR; k++) begin
                if (flush && m_pend[k] && (cyc - m_issue[k] <= SPEC)) begin
                    m_pend[k] = 1'b0;
                end else if (wbv && int'(wbrd) == k) begin
                    m_pend[k] = 1'b0;
                end else if (issue_valid && e_ready && we && int'(rd) == k) begin
                    m_pend[k]  = 1'b1;
                    m_issue[k] = cyc;
                    m_lat[k]   = int'(lat);
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit v, input int r0, input int r1, input logic [1:0] u,
                       input bit w, input int d, input int l,
                       input bit wv, input int wr, input bit f);
        @(posedge clk);
        #2;
        issue_valid = v;
        rs          = {AW'(r1), AW'(r0)};
        used        = u;
        we          = w;
        rd          = AW'(d);
        lat         = LW'(l);
        wbv         = wv;
        wbrd        = AW'(wr);
        flush       = f;
    endtask

    task automatic idle();
        drv(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    int lsel;
    int lv;

    initial begin
        reset_n = 1'b0;
        issue_valid = 1'b0; rs = '0; used = '0; we = 1'b0; rd = '0;
        lat = '0; wbv = 1'b0; wbrd = '0; flush = 1'b0;
        idle();
        idle();
        reset_n = 1'b1;
        at_sample();
        chk("reset_busy",  64'(busy),  64'd0);
        chk("reset_fwd",   64'(fwd),   64'd0);
        chk("reset_ready", 64'(ready), 64'd1);

        // ALU producer: next-cycle consumer takes the bypass.
        drv(1'b1, 0, 0, 2'b00, 1'b1, 5, int'(LAT_ALU), 1'b0, 0, 1'b0);
        drv(1'b1, 5, 0, 2'b01, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        at_sample();
        chk("alu_ready", 64'(ready), 64'd1);
        chk("alu_fwd",   64'(fwd),   64'b01);

        // Latency-3 producer: stalls three cycles, then bypass.
        drv(1'b1, 0, 0, 2'b00, 1'b1, 7, int'(LAT_MUL), 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 0, 7, 2'b10, 1'b0, 0, 0, 1'b0, 0, 1'b0);
            at_sample();
            chk("mul_stall", 64'(ready), 64'd0);
        end
        drv(1'b1, 0, 7, 2'b10, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        at_sample();
        chk("mul_ready", 64'(ready),   64'd1);
        chk("mul_fwd",   64'(fwd),     64'b10);
        chk("mul_busy",  64'(busy[7]), 64'd1);
        drv(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b1, 7, 1'b0);
        drv(1'b0, 0, 7, 2'b10, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        at_sample();
        chk("wb7_busy", 64'(busy[7]), 64'd0);
        chk("wb7_fwd",  64'(fwd),     64'd0);

        // WAW: second write to r9 waits for its writeback.
        drv(1'b1, 0, 0, 2'b00, 1'b1, 9, 5, 1'b0, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, 0, 0, 2'b00, 1'b1, 9, 1, 1'b0, 0, 1'b0);
            at_sample();
            chk("waw_stall", 64'(ready), 64'd0);
        end
        drv(1'b1, 0, 0, 2'b00, 1'b1, 9, 1, 1'b1, 9, 1'b0);
        at_sample();
        chk("waw_wb_cycle", 64'(ready), 64'd0);
        drv(1'b1, 0, 0, 2'b00, 1'b1, 9, 1, 1'b0, 0, 1'b0);
        at_sample();
        chk("waw_release", 64'(ready), 64'd1);
        drv(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b1, 9, 1'b0);
        drv(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b1, 5, 1'b0);

        // Flush squashes only entries still inside their speculation window.
        drv(1'b1, 0, 0, 2'b00, 1'b1, 3, 4, 1'b0, 0, 1'b0);
        idle();
        drv(1'b1, 0, 0, 2'b00, 1'b1, 4, 4, 1'b0, 0, 1'b0);
        drv(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        at_sample();
        chk("flush_ready", 64'(ready), 64'd0);
        idle();
        at_sample();
        chk("flush_r4", 64'(busy[4]), 64'd0);
        chk("flush_r3", 64'(busy[3]), 64'd1);
        drv(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b1, 3, 1'b0);

        // Register 0 is never tracked.
        drv(1'b1, 0, 0, 2'b00, 1'b1, 0, 9, 1'b0, 0, 1'b0);
        drv(1'b1, 0, 0, 2'b11, 1'b1, 0, 0, 1'b0, 0, 1'b0);
        at_sample();
        chk("r0_ready", 64'(ready),   64'd1);
        chk("r0_fwd",   64'(fwd),     64'd0);
        chk("r0_busy",  64'(busy[0]), 64'd0);

`ifdef HAZARD_SCOREBOARD_PERF_EN
        idle();
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        drv(1'b1, 0, 0, 2'b00, 1'b1, 6, 5, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) drv(1'b1, 6, 0, 2'b01, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        drv(1'b1, 6, 0, 2'b01, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle();
        at_sample();
        chk("perf_stalls", 64'(stall_cyc), 64'd3);
        chk("perf_waw",    64'(waw_st),    64'd0);
        idle();
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        at_sample();
        chk("perf_reset_cnt",  64'(stall_cyc), 64'd0);
        chk("perf_reset_busy", 64'(busy),      64'd0);
`endif

        // Randomized traffic on a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            lsel = int'($urandom_range(0, 3));
            case (lsel)
                0:       lv = int'(LAT_ALU);
                1:       lv = int'(LAT_LOAD);
                2:       lv = int'(LAT_MUL);
                default: lv = int'($urandom_range(0, int'(LAT_DIV_MAX)));
            endcase
            drv(($urandom_range(0, 9) < 7),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), lv,
                ($urandom_range(0, 99) < 35), int'($urandom_range(0, 7)),
                ($urandom_range(0, 99) < 5));
            reset_n = ($urandom_range(0, 199) != 0);
        end
        reset_n = 1'b1;
        idle();
        at_sample();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, stateful successor to the pipeline hazard/stall control.
- Tracks one entry per architectural register for in-flight writes from variable-latency producers: ALU (0), load (2), mul (3), div (up to 15).
- Decides at issue (ID->EX) whether an instruction stalls, takes a bypass, or proceeds.
- Squashes speculative entries on a control-hazard flush.
- Sits beside the decode/issue point; consumed by the stall/valid logic that drives pc_reg_stall, id_reg_stall and ex_reg_valid.

Parameters:
NUM_REGS, 32, number of tracked architectural registers; register 0 is never tracked
REG_ADDR_W, 5, register address width, $clog2(NUM_REGS)
NUM_SRC, 2, source operands checked per issuing instruction
LAT_W, 4, width of producer latency field; maximum latency 2**LAT_W-1
SPEC_CYCLES, 2, cycles after issue during which an entry is still squashable by flush_i (1..7)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous reset, active-low
issue_valid_i  in  1  instruction presented for issue
issue_ready_o  out  1  instruction may issue this cycle
issue_rs_i  in  NUM_SRC*REG_ADDR_W  packed source register addresses, src 0 in LSBs
issue_rs_used_i  in  NUM_SRC  per-source "operand actually read"
issue_we_i  in  1  instruction writes a register
issue_rd_i  in  REG_ADDR_W  destination register
issue_lat_i  in  LAT_W  cycles until result is forwardable (0 = ALU, next-cycle bypass)
wb_valid_i  in  1  register file write this cycle
wb_rd_i  in  REG_ADDR_W  register being written back
flush_i  in  1  control hazard; squash speculative entries
src_fwd_o  out  NUM_SRC  per-source: must take bypass instead of regfile
busy_o  out  NUM_REGS  per-register pending-write flag (debug/trace)

Behaviour:
- Entry state per register: busy (1b), cnt (LAT_W), spec (1b), age (3b).
- Reset (reset_i==0 at a clock edge): all busy/cnt/spec/age = 0. busy_o = 0 and src_fwd_o = 0 the cycle after. issue_ready_o = !flush_i (combinational from state).
- Issue fires when issue_valid_i && issue_ready_o.
  - If issue_we_i && issue_rd_i != 0 on fire: busy=1, cnt=issue_lat_i, spec=1, age=SPEC_CYCLES, all at the next edge.
- Countdown: every cycle, each busy entry with cnt != 0 decrements by 1, saturating at 0.
  - Timing: producer fires at T with latency L; a dependent may fire at T+1+L.
- Spec aging: age decrements each cycle while != 0; spec clears when age reaches 0 (on the same edge).
- Source hazard i: issue_rs_used_i[i] && rs_i != 0 && busy[rs_i] && cnt[rs_i] != 0.
- WAW hazard: issue_we_i && issue_rd_i != 0 && busy[issue_rd_i].
- issue_ready_o = !flush_i && no source hazard && no WAW hazard. Independent of issue_valid_i, so there is no combinational loop.
- src_fwd_o[i] = issue_rs_used_i[i] && rs_i != 0 && busy[rs_i] && cnt[rs_i] == 0. Combinational; valid whether or not the instruction issues.
- Writeback: wb_valid_i && wb_rd_i != 0 clears busy, cnt, spec and age of that entry at the next edge.
- Flush: every entry with spec=1 is cleared. Non-speculative entries survive. An issue in a flush cycle is impossible (ready=0).
- Precedence per entry on one edge: reset > flush (if spec) > writeback > new issue > countdown/aging.
  - Issue and writeback to the same rd in one cycle cannot both happen, because WAW holds ready low. If an external bench forces it, writeback wins.
- rd or rs == 0: never busy, never stalls, never forwards.
- Reset mid-operation: all in-flight tracking is lost. The pipeline must be flushed by the same reset.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- When defined:
  - Adds port stall_cycles_o, out, 32 bits.
  - Counts cycles with issue_valid_i && !issue_ready_o && !flush_i.
  - Reset to 0; wraps at 2**32.
  - Also adds waw_stalls_o, 16 bits, counting stall cycles where a WAW hazard is present. Saturates at 16'hFFFF.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- definitions package gets:
  - sb_entry_t struct {busy, cnt, spec, age}.
  - Latency constants: LAT_ALU=0, LAT_LOAD=2, LAT_MUL=3, LAT_DIV_MAX=15.
  - SB_SPEC_CYCLES default.
- Sub-module hazard_scoreboard_entry:
  - One register entry with its next-state/precedence logic.
  - Instantiated NUM_REGS-1 times by generate.
  - Hazard/ready/forward reduction stays in the top.

Test Plan:
- Reset, then issue rd=5 with lat=0; next cycle rs0=5 -> ready=1, src_fwd_o[0]=1.
- Issue rd=7 with lat=3 at T. Dependent rs1=7 presented at T+1..T+3 -> ready=0. At T+4 -> ready=1, src_fwd_o[1]=1. wb rd=7 at T+5 -> busy_o[7]=0, fwd=0.
- Issue rd=9 with lat=5, then another write to rd=9 -> ready=0 (WAW) until wb rd=9; ready=1 the cycle after.
- Issue rd=3 (lat=4) at T and rd=4 (lat=4) at T+2; flush at T+3 -> busy_o[4]=0 (spec), busy_o[3]=1 (aged out).
- rs=0 and rd=0 with rs_used=1 and a busy-looking history -> never stall, never forward, busy_o[0]=0 always.
- With HAZARD_SCOREBOARD_PERF_EN: 3 stalled valid cycles plus 1 flush cycle -> stall_cycles_o=3. Assert reset_i=0 for one edge -> stall_cycles_o=0 and busy_o all 0.
